tank_move_ctrl: RTL and testbench
=================================

Name: tank_move_ctrl

Overview:
Per-player tank controller. It sequences one tank's position and heading from debounced joystick levels, paced by the VGA frame tick. Every move is checked against the tile map through a shared 1-cycle-latency map read port before it is committed. It also issues bullet-spawn requests to the bullet engine over a req/ack handshake. Its outputs drive the VGA tank inputs (x, y, dir) directly.

Parameters:
MAX_X, 39, largest legal tile column (40x30 grid of 16px tiles)
MAX_Y, 29, largest legal tile row
INIT_X, 2, reset column
INIT_Y, 2, reset row
INIT_DIR, 0, reset heading
MOVE_PERIOD, 8, frames per movement step (>=1)
FIRE_COOLDOWN, 30, frames after a spawn ack before the next request is allowed

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous active-low
i_frame_tick  in  1  one-cycle pulse per VGA frame
i_enable  in  1  play state active; 0 freezes the tank
i_up/i_down/i_left/i_right  in  1 each  debounced joystick levels, active-high
i_fire  in  1  debounced fire level, active-high
o_map_x  out  6  map query column
o_map_y  out  6  map query row
o_map_rd  out  1  map query strobe
i_map_wall  in  1  wall flag, valid exactly 1 cycle after o_map_rd
o_tank_x  out  6  tank column
o_tank_y  out  6  tank row
o_tank_dir  out  2  heading: 0 up, 1 right, 2 down, 3 left
o_fire_req  out  1  bullet spawn request
o_fire_x/o_fire_y  out  6 each  spawn tile
o_fire_dir  out  2  spawn heading
i_fire_ack  in  1  spawn accepted

Behaviour:
- Reset values: tank = (INIT_X, INIT_Y, INIT_DIR); o_map_rd=0; o_map_x/y=0; o_fire_req=0; o_fire_x/y/dir=0; move counter=0; cooldown=0; FSM=IDLE.
- Move counter: counts i_frame_tick pulses 0..MOVE_PERIOD-1 and wraps. The step event is a tick that arrives while the counter is at MOVE_PERIOD-1.
- Direction pick: priority up > down > left > right. No direction pressed means no action.
- FSM states and transitions:
  - IDLE: on a step event with i_enable=1 and a direction pressed:
    - If the picked dir differs from o_tank_dir: rotate only (o_tank_dir updated next cycle, no move) and stay in IDLE.
    - Otherwise compute the target tile. If the target is off-grid (x=0 going left, x=MAX_X going right, y=0 going up, y=MAX_Y going down): no action.
    - Otherwise go to QUERY.
  - QUERY (1 cycle): o_map_rd=1, o_map_x/y = target. Go to CHECK.
  - CHECK (1 cycle): sample i_map_wall. 0 means commit the target to o_tank_x/y; 1 means hold position. Return to IDLE.
- Move latency: the position changes 3 clk cycles after the step tick.
- Step events arriving in QUERY or CHECK are ignored. The counter still wraps.
- i_enable=0: no new moves or fire requests start. An in-flight QUERY/CHECK still completes. The counter and cooldown freeze.
- Fire:
  - Cooldown decrements by 1 per frame tick and saturates at 0.
  - When o_fire_req=0, cooldown=0, i_fire=1 and i_enable=1: assert o_fire_req next cycle. Latch o_fire_x/y/dir from the current tank state (pre-move if a commit happens in the same cycle).
  - o_fire_req and its payload stay stable until a cycle with i_fire_ack=1. That cycle clears the request and loads cooldown with FIRE_COOLDOWN.
  - i_fire_ack while o_fire_req=0 is ignored.
  - Holding i_fire re-fires once per cooldown expiry.
- Asynchronous reset mid-operation returns every register to its reset value immediately. Any pending request is dropped.

Optional Feature:
Macro TANK_MOVE_CTRL_WRAP_EN.
- Defined: off-grid targets wrap (x=0 going left targets MAX_X, y=MAX_Y going down targets 0, etc.) and still go through the map query.
- Undefined: off-grid targets are blocked as described in Behaviour.

Test Plan:
1. Reset, then idle 20 frames -> tank stays at (2,2,0); o_fire_req=0; o_map_rd never asserted.
2. Hold i_right with dir=0, map all clear -> 1st step rotates to dir=1 with position (2,2); 2nd step queries (3,2) and o_tank_x=3 exactly 3 clk after the step tick.
3. Hold i_up and i_left together, i_map_wall=1 on the query -> dir=0; query at (2,1); position stays (2,2).
4. Tank at (0,5) dir=3, hold i_left -> without macro: no o_map_rd and x stays 0; with macro: query at (39,5) and x becomes 39.
5. Hold i_fire, ack 4 cycles later -> o_fire_req high for exactly 4 cycles with payload (2,2,0) stable; the next request appears only after 30 frame ticks.
6. Assert rst_n=0 during CHECK with a fire request pending -> all outputs return to reset values immediately and nothing is committed after release.

Source files
------------

// File: rtl/tank_move_ctrl.sv
// Per-player tank controller: frame-paced stepping, map-checked moves, bullet spawn requests.
// Define TANK_MOVE_CTRL_WRAP_EN to wrap off-grid targets to the opposite edge instead of blocking them.
//
// state   | meaning
// S_IDLE  | waiting for a step event; rotations are applied here
// S_QUERY | map read strobe out for the target tile
// S_CHECK | wall flag sampled; target committed when clear
module tank_move_ctrl #(
  parameter int MAX_X         = 39,
  parameter int MAX_Y         = 29,
  parameter int INIT_X        = 2,
  parameter int INIT_Y        = 2,
  parameter int INIT_DIR      = 0,
  parameter int MOVE_PERIOD   = 8,
  parameter int FIRE_COOLDOWN = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic       i_enable,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_fire,
  output logic [5:0] o_map_x,
  output logic [5:0] o_map_y,
  output logic       o_map_rd,
  input  logic       i_map_wall,
  output logic [5:0] o_tank_x,
  output logic [5:0] o_tank_y,
  output logic [1:0] o_tank_dir,
  output logic       o_fire_req,
  output logic [5:0] o_fire_x,
  output logic [5:0] o_fire_y,
  output logic [1:0] o_fire_dir,
  input  logic       i_fire_ack
);

  localparam int CW = $clog2(MOVE_PERIOD + 1);
  localparam int KW = $clog2(FIRE_COOLDOWN + 1);
  localparam logic [5:0] MAX_X6 = 6'(MAX_X);
  localparam logic [5:0] MAX_Y6 = 6'(MAX_Y);

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_CHECK} state_t;

  state_t        state;
  logic [CW-1:0] move_cnt;
  logic [KW-1:0] cooldown;

  logic       has_dir;
  logic [1:0] pick_dir;
  logic [5:0] tgt_x;
  logic [5:0] tgt_y;
  logic       at_edge;
  logic       blocked;
  logic       tick_en;
  logic       cnt_last;
  logic       step;

  assign tick_en  = i_frame_tick & i_enable;
  assign cnt_last = (move_cnt == CW'(MOVE_PERIOD - 1));
  assign step     = tick_en & cnt_last;

  always_comb begin
    has_dir = i_up | i_down | i_left | i_right;
    if (i_up)        pick_dir = 2'd0;
    else if (i_down) pick_dir = 2'd2;
    else if (i_left) pick_dir = 2'd3;
    else             pick_dir = 2'd1;
    tgt_x   = o_tank_x;
    tgt_y   = o_tank_y;
    at_edge = 1'b0;
    case (pick_dir)
      2'd0: begin
        at_edge = (o_tank_y == 6'd0);
        tgt_y   = at_edge ? MAX_Y6 : o_tank_y - 6'd1;
      end
      2'd1: begin
        at_edge = (o_tank_x == MAX_X6);
        tgt_x   = at_edge ? 6'd0 : o_tank_x + 6'd1;
      end
      2'd2: begin
        at_edge = (o_tank_y == MAX_Y6);
        tgt_y   = at_edge ? 6'd0 : o_tank_y + 6'd1;
      end
      default: begin
        at_edge = (o_tank_x == 6'd0);
        tgt_x   = at_edge ? MAX_X6 : o_tank_x - 6'd1;
      end
    endcase
`ifdef TANK_MOVE_CTRL_WRAP_EN
    blocked = 1'b0;
`else
    blocked = at_edge;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      move_cnt   <= '0;
      cooldown   <= '0;
      o_map_rd   <= 1'b0;
      o_map_x    <= 6'd0;
      o_map_y    <= 6'd0;
      o_tank_x   <= 6'(INIT_X);
      o_tank_y   <= 6'(INIT_Y);
      o_tank_dir <= 2'(INIT_DIR);
      o_fire_req <= 1'b0;
      o_fire_x   <= 6'd0;
      o_fire_y   <= 6'd0;
      o_fire_dir <= 2'd0;
    end else begin
      if (tick_en) move_cnt <= cnt_last ? '0 : move_cnt + CW'(1);
      o_map_rd <= 1'b0;

      case (state)
        S_IDLE: begin
          if (step && has_dir) begin
            if (pick_dir != o_tank_dir) begin
              o_tank_dir <= pick_dir;
            end else if (!blocked) begin
              o_map_rd <= 1'b1;
              o_map_x  <= tgt_x;
              o_map_y  <= tgt_y;
              state    <= S_QUERY;
            end
          end
        end
        S_QUERY: state <= S_CHECK;
        S_CHECK: begin
          // wall flag arrives one cycle after the strobe, i.e. now
          if (!i_map_wall) begin
            o_tank_x <= o_map_x;
            o_tank_y <= o_map_y;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (o_fire_req && i_fire_ack) begin
        o_fire_req <= 1'b0;
        cooldown   <= KW'(FIRE_COOLDOWN);
      end else begin
        if (tick_en && cooldown != '0) cooldown <= cooldown - KW'(1);
        // payload captures the pre-commit tank state
        if (!o_fire_req && cooldown == '0 && i_fire && i_enable) begin
          o_fire_req <= 1'b1;
          o_fire_x   <= o_tank_x;
          o_fire_y   <= o_tank_y;
          o_fire_dir <= o_tank_dir;
        end
      end
    end
  end

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Scoreboard bench for tank_move_ctrl: directed step vectors, fire handshake and mid-check reset.
// Expectations follow TANK_MOVE_CTRL_WRAP_EN when it is defined for the build.
module tb_tank_move_ctrl;

  localparam int MP  = 8;
  localparam int GAP = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_frame_tick, i_enable, i_up, i_down, i_left, i_right, i_fire;
  logic [5:0] o_map_x, o_map_y;
  logic       o_map_rd;
  logic       i_map_wall = 1'b0;
  logic [5:0] o_tank_x, o_tank_y;
  logic [1:0] o_tank_dir;
  logic       o_fire_req;
  logic [5:0] o_fire_x, o_fire_y;
  logic [1:0] o_fire_dir;
  logic       i_fire_ack;

  tank_move_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_frame_tick(i_frame_tick), .i_enable(i_enable),
    .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right), .i_fire(i_fire),
    .o_map_x(o_map_x), .o_map_y(o_map_y), .o_map_rd(o_map_rd), .i_map_wall(i_map_wall),
    .o_tank_x(o_tank_x), .o_tank_y(o_tank_y), .o_tank_dir(o_tank_dir),
    .o_fire_req(o_fire_req), .o_fire_x(o_fire_x), .o_fire_y(o_fire_y),
    .o_fire_dir(o_fire_dir), .i_fire_ack(i_fire_ack)
  );

  always #5 clk = ~clk;

  // Map responder: single wall tile at (3,1), answered one cycle after the strobe.
  always @(posedge clk) i_map_wall <= o_map_rd && o_map_x == 6'd3 && o_map_y == 6'd1;

  int n_cmp = 0;
  int n_err = 0;
  int ph    = 0;
  logic [15:0] exp_q[$];

  typedef struct packed {
    logic [3:0] btn;
    logic       q;
    logic [5:0] qx, qy, px, py;
    logic [1:0] pd;
  } vec_t;

  function automatic vec_t mk(logic [3:0] btn, logic q, logic [5:0] qx, logic [5:0] qy,
                              logic [5:0] px, logic [5:0] py, logic [1:0] pd);
    vec_t v;
    v.btn = btn; v.q = q; v.qx = qx; v.qy = qy; v.px = px; v.py = py; v.pd = pd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic got(input logic [15:0] ev);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got %0h expected none at %0t", ev, $time);
    end else begin
      chk("sb_event", ev, exp_q.pop_front());
    end
  endtask

  // Monitor: query strobes, tank state changes and fire request rises become events.
  logic [13:0] prev_pos  = {6'd2, 6'd2, 2'd0};
  logic        prev_fire = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_map_rd) got({2'd1, o_map_x, o_map_y, 2'd0});
      if ({o_tank_x, o_tank_y, o_tank_dir} != prev_pos) got({2'd2, o_tank_x, o_tank_y, o_tank_dir});
      if (o_fire_req && !prev_fire) got({2'd3, o_fire_x, o_fire_y, o_fire_dir});
    end
    prev_pos  = {o_tank_x, o_tank_y, o_tank_dir};
    prev_fire = o_fire_req;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    i_frame_tick = 1'b1;
    cyc(1);
    i_frame_tick = 1'b0;
    if (i_enable) ph = (ph + 1) % MP;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      do_tick();
      cyc(GAP);
    end
  endtask

  // Returns one ns after the edge that samples the step tick.
  task automatic step_tick();
    while (ph != MP - 1) begin
      do_tick();
      cyc(GAP);
    end
    do_tick();
  endtask

  task automatic set_btn(input logic [3:0] b);
    {i_up, i_down, i_left, i_right} = b;
  endtask

  logic [13:0] cur = {6'd2, 6'd2, 2'd0};

  task automatic run_vec(input vec_t v);
    set_btn(v.btn);
    if (v.q) exp_q.push_back({2'd1, v.qx, v.qy, 2'd0});
    if ({v.px, v.py, v.pd} != cur) exp_q.push_back({2'd2, v.px, v.py, v.pd});
    step_tick();
    chk("map_rd", o_map_rd, v.q);
    cyc(1);
    if (v.q) chk("pos_hold_latency", {o_tank_x, o_tank_y}, cur[13:2]);
    cyc(1);
    chk("pos_final", {o_tank_x, o_tank_y, o_tank_dir}, {v.px, v.py, v.pd});
    cur = {v.px, v.py, v.pd};
    cyc(GAP);
  endtask

  localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001;
  vec_t vecs[16];

  initial begin
    rst_n = 1'b0; i_frame_tick = 1'b0; i_enable = 1'b1; i_fire = 1'b0; i_fire_ack = 1'b0;
    set_btn(4'b0);

    vecs[0]  = mk(4'b0, 0, 0, 0, 2, 2, 0);
    vecs[1]  = mk(R,     0, 0, 0, 2, 2, 1);
    vecs[2]  = mk(R,     1, 3, 2, 3, 2, 1);
    vecs[3]  = mk(U | L, 0, 0, 0, 3, 2, 0);
    vecs[4]  = mk(U | L, 1, 3, 1, 3, 2, 0);
    vecs[5]  = mk(L,     0, 0, 0, 3, 2, 3);
    vecs[6]  = mk(L,     1, 2, 2, 2, 2, 3);
    vecs[7]  = mk(L,     1, 1, 2, 1, 2, 3);
    vecs[8]  = mk(L,     1, 0, 2, 0, 2, 3);
    vecs[9]  = mk(D,     0, 0, 0, 0, 2, 2);
    vecs[10] = mk(D,     1, 0, 3, 0, 3, 2);
    vecs[11] = mk(D,     1, 0, 4, 0, 4, 2);
    vecs[12] = mk(D,     1, 0, 5, 0, 5, 2);
    vecs[13] = mk(L,     0, 0, 0, 0, 5, 3);
`ifdef TANK_MOVE_CTRL_WRAP_EN
    vecs[14] = mk(L,     1, 39, 5, 39, 5, 3);
    vecs[15] = mk(R,     0, 0, 0, 39, 5, 1);
`else
    vecs[14] = mk(L,     0, 0, 0, 0, 5, 3);
    vecs[15] = mk(R,     0, 0, 0, 0, 5, 1);
`endif

    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("reset_pos", {o_tank_x, o_tank_y, o_tank_dir}, {6'd2, 6'd2, 2'd0});
    chk("reset_fire", {o_fire_req, o_fire_x, o_fire_y, o_fire_dir}, 15'd0);
    chk("reset_map", {o_map_rd, o_map_x, o_map_y}, 13'd0);

    // idle frames: nothing moves, nothing queried
    ticks(20);
    chk("idle_pos", {o_tank_x, o_tank_y, o_tank_dir}, {6'd2, 6'd2, 2'd0});
    chk("idle_fire", o_fire_req, 1'b0);

    // fire handshake and cooldown
    exp_q.push_back({2'd3, 6'd2, 6'd2, 2'd0});
    i_fire = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("fire_req_high", {o_fire_req, o_fire_x, o_fire_y, o_fire_dir}, {1'b1, 6'd2, 6'd2, 2'd0});
    end
    i_fire_ack = 1'b1;
    cyc(1);
    i_fire_ack = 1'b0;
    chk("fire_req_cleared", o_fire_req, 1'b0);
    ticks(29);
    chk("fire_cooldown_29", o_fire_req, 1'b0);
    exp_q.push_back({2'd3, 6'd2, 6'd2, 2'd0});
    do_tick();
    chk("fire_cooldown_30", o_fire_req, 1'b0);
    cyc(1);
    chk("fire_refire", o_fire_req, 1'b1);
    i_fire_ack = 1'b1;
    cyc(1);
    i_fire_ack = 1'b0;
    i_fire = 1'b0;
    chk("fire_ack2", o_fire_req, 1'b0);
    i_fire_ack = 1'b1;
    cyc(1);
    i_fire_ack = 1'b0;
    cyc(1);
    chk("stray_ack", o_fire_req, 1'b0);
    cyc(GAP);

    // disabled: counter frozen, no action with a direction held
    i_enable = 1'b0;
    set_btn(R);
    ticks(MP);
    chk("disabled_pos", {o_tank_x, o_tank_y, o_tank_dir}, {6'd2, 6'd2, 2'd0});
    i_enable = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // reset in CHECK with a fire request pending
    i_fire = 1'b1;
    exp_q.push_back({2'd3, cur});
    cyc(1);
    chk("pend_fire", o_fire_req, 1'b1);
    run_vec(vecs[15]);
    set_btn(R);
`ifdef TANK_MOVE_CTRL_WRAP_EN
    exp_q.push_back({2'd1, 6'd0, 6'd5, 2'd0});
`else
    exp_q.push_back({2'd1, 6'd1, 6'd5, 2'd0});
`endif
    step_tick();
    chk("rst_query", o_map_rd, 1'b1);
    cyc(1);
    rst_n = 1'b0;
    i_fire = 1'b0;
    set_btn(4'b0);
    #1;
    chk("rst_async_pos", {o_tank_x, o_tank_y, o_tank_dir}, {6'd2, 6'd2, 2'd0});
    chk("rst_async_fire", {o_fire_req, o_fire_x, o_fire_y, o_fire_dir}, 15'd0);
    chk("rst_async_map", {o_map_rd, o_map_x, o_map_y}, 13'd0);
    cyc(2);
    rst_n = 1'b1;
    ph = 0;
    cyc(20);
    chk("post_rst_pos", {o_tank_x, o_tank_y, o_tank_dir}, {6'd2, 6'd2, 2'd0});
    chk("post_rst_fire", o_fire_req, 1'b0);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
